// File: rtl/qspi_fifo_drain.sv
// qspi_fifo_drain: read-side consumer of an async FIFO (rclk domain).
// On start, pops word_cnt words and shifts each out MSB-first as quad-SPI
// nibbles with a self-generated mode-0 serial clock (idle low).
// Optional build macro QSPI_DRAIN_UNDERRUN_ABORT_EN: an empty FIFO at fetch
// time aborts the burst with an underrun pulse instead of waiting.
module qspi_fifo_drain #(
  parameter int DATAWIDTH = 16,
  parameter int CNTW      = 10,
  parameter int CLKDIV    = 2
) (
  input  logic                 rclk,
  input  logic                 rrstn,
  input  logic                 start,
  input  logic [CNTW-1:0]      word_cnt,
  output logic                 ren,
  input  logic [DATAWIDTH-1:0] rdata,
  input  logic                 rempty,
  output logic                 qspi_sclk,
  output logic [3:0]           qspi_io_o,
  output logic                 qspi_io_oe,
  output logic                 busy,
  output logic                 done,
  output logic                 underrun
);

  localparam int NIBS = DATAWIDTH / 4;
  localparam int NW   = $clog2(NIBS + 1);
  localparam int DIVW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [CNTW-1:0]      rem_q, rem_d;
  logic [DATAWIDTH-1:0] shreg_q, shreg_d;
  logic [NW-1:0]        nib_q, nib_d;
  logic [DIVW-1:0]      div_q, div_d;
  logic                 sclk_q, sclk_d;
  logic [3:0]           io_q, io_d;
  logic                 oe_q, oe_d;
  logic                 busy_q, busy_d;

  logic                 phase_end_s;
  logic                 last_nib_s;
  logic                 shift_exit_s;
  logic                 abort_s;
  logic [DATAWIDTH-1:0] shreg_nxt_s;

  assign phase_end_s  = (div_q == DIVW'(CLKDIV - 1));
  assign last_nib_s   = (nib_q == NW'(1));
  assign shift_exit_s = (state_q == S_SHIFT) && phase_end_s && sclk_q && last_nib_s;
  assign shreg_nxt_s  = shreg_q << 4;

`ifdef QSPI_DRAIN_UNDERRUN_ABORT_EN
  assign abort_s = (state_q == S_FETCH) && rempty;
`else
  assign abort_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: sequence FETCH/LOAD/SHIFT/NEXT per word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (word_cnt != '0) state_d = S_FETCH;
          else                state_d = S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (!rempty) begin
          state_d = S_LOAD;
        end else begin
`ifdef QSPI_DRAIN_UNDERRUN_ABORT_EN
          state_d = S_IDLE;
`else
          state_d = S_FETCH;
`endif
        end
      end
      S_LOAD:  state_d = S_SHIFT;
      S_SHIFT: begin
        if (shift_exit_s) state_d = S_NEXT;
        else              state_d = S_SHIFT;
      end
      S_NEXT: begin
        if (rem_q == '0) state_d = S_DONE;
        else             state_d = S_FETCH;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: pop only while fetching with data present; done/underrun pulses.
  always_comb begin
    ren      = (state_q == S_FETCH) && !rempty;
    done     = (state_q == S_DONE) || abort_s;
    underrun = abort_s;
  end

  // Datapath next-state: word counter, shift register, sclk divider and pins.
  always_comb begin
    rem_d   = rem_q;
    shreg_d = shreg_q;
    nib_d   = nib_q;
    div_d   = div_q;
    sclk_d  = sclk_q;
    io_d    = io_q;
    oe_d    = oe_q;
    busy_d  = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start && (word_cnt != '0)) rem_d = word_cnt;
        else                           rem_d = rem_q;
      end
      S_LOAD: begin
        shreg_d = rdata;
        io_d    = rdata[DATAWIDTH-1 -: 4];
        nib_d   = NW'(NIBS);
        oe_d    = 1'b1;
        div_d   = '0;
        sclk_d  = 1'b0;
      end
      S_SHIFT: begin
        if (!phase_end_s) begin
          div_d = div_q + DIVW'(1);
        end else begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Falling edge: either move to the next nibble or finish the word.
            sclk_d = 1'b0;
            if (last_nib_s) begin
              oe_d  = 1'b0;
              io_d  = 4'h0;
              rem_d = rem_q - CNTW'(1);
            end else begin
              shreg_d = shreg_nxt_s;
              io_d    = shreg_nxt_s[DATAWIDTH-1 -: 4];
              nib_d   = nib_q - NW'(1);
            end
          end
        end
      end
      default: begin
        rem_d = rem_q;
      end
    endcase
  end

  // Datapath registers; all cleared by the asynchronous reset.
  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn) begin
      rem_q   <= '0;
      shreg_q <= '0;
      nib_q   <= '0;
      div_q   <= '0;
      sclk_q  <= 1'b0;
      io_q    <= 4'h0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      shreg_q <= shreg_d;
      nib_q   <= nib_d;
      div_q   <= div_d;
      sclk_q  <= sclk_d;
      io_q    <= io_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
    end
  end

  assign qspi_sclk  = sclk_q;
  assign qspi_io_o  = io_q;
  assign qspi_io_oe = oe_q;
  assign busy       = busy_q;

endmodule
